// File: rtl/reg_fwd_pkg.sv
// Shared state encoding and select-width helper for the native register forwarder.
package reg_fwd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fwd_state_e;

  function automatic int sel_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reg_fwd_timer.sv
// Wait-cycle counter: load starts the count at 1, inc advances it, expired_o flags the limit.
// A zero limit removes the counter entirely so the transaction can wait forever.
module reg_fwd_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic inc_i,
  output logic expired_o
);

  if (TIMEOUT_CYCLES == 0) begin : g_stub
    logic unused_ok;
    assign unused_ok = &{1'b0, clk_i, rst_i, load_i, inc_i};
    assign expired_o = 1'b0;
  end else begin : g_cnt
    localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
        cnt_d = CW'(1);
      end else if (inc_i && (cnt_q != LIMIT)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == LIMIT);
  end

endmodule

// File: rtl/reg_native_if_ext_fwd.sv
// Forwards native register requests to one of N_EXT external IP ports, one transaction in flight.
// All outputs registered; requests while busy are dropped (err_overrun), stray acks flag err_spurious.
module reg_native_if_ext_fwd
  import reg_fwd_pkg::*;
#(
  parameter int          BUS_DATA_WIDTH = 32,
  parameter int          BUS_ADDR_WIDTH = 64,
  parameter int          N_EXT          = 4,
  parameter int          SEL_LSB        = 16,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                            native_clk,
  input  logic                            native_rst,
  input  logic                            req_vld,
  input  logic [BUS_ADDR_WIDTH-1:0]       addr,
  input  logic                            wr_en,
  input  logic                            rd_en,
  input  logic [BUS_DATA_WIDTH-1:0]       wr_data,
  output logic                            ack_vld,
  output logic [BUS_DATA_WIDTH-1:0]       rd_data,
  output logic [N_EXT-1:0]                ext_req_vld,
  output logic [BUS_ADDR_WIDTH-1:0]       ext_addr,
  output logic                            ext_wr_en,
  output logic                            ext_rd_en,
  output logic [BUS_DATA_WIDTH-1:0]       ext_wr_data,
  input  logic [N_EXT-1:0]                ext_ack_vld,
  input  logic [N_EXT*BUS_DATA_WIDTH-1:0] ext_rd_data,
  output logic                            err_timeout,
  output logic                            err_decode,
  output logic                            err_overrun,
  output logic                            err_spurious
);

  localparam int                        SEL_W  = sel_w(N_EXT);
  localparam logic [BUS_DATA_WIDTH-1:0] ERR_RD = BUS_DATA_WIDTH'(ERR_DATA);

  typedef struct packed {
    logic [BUS_ADDR_WIDTH-1:0] addr;
    logic                      wr_en;
    logic                      rd_en;
    logic [BUS_DATA_WIDTH-1:0] wr_data;
  } req_t;

  fwd_state_e                state_q, state_d;
  logic [SEL_W-1:0]          sel_q, sel_d, req_sel;
  req_t                      req_q, req_d;
  logic [BUS_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [N_EXT-1:0]          ext_req_q, ext_req_d, sel_mask;
  logic                      ack_q, ack_d;
  logic                      err_to_q, err_to_d, err_dec_q, err_dec_d;
  logic                      err_ovr_q, err_ovr_d, err_spur_q, err_spur_d;
  logic                      tmr_load, tmr_inc, tmr_expired;

  assign req_sel  = addr[SEL_LSB +: SEL_W];
  assign sel_mask = N_EXT'(1) << sel_q;

  reg_fwd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (native_clk),
    .rst_i    (native_rst),
    .load_i   (tmr_load),
    .inc_i    (tmr_inc),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    req_d      = req_q;
    rd_data_d  = rd_data_q;
    ext_req_d  = '0;
    ack_d      = 1'b0;
    err_to_d   = 1'b0;
    err_dec_d  = 1'b0;
    err_ovr_d  = 1'b0;
    err_spur_d = 1'b0;
    tmr_load   = 1'b0;
    tmr_inc    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        err_spur_d = |ext_ack_vld;
        if (req_vld) begin
          if (32'(req_sel) < N_EXT) begin
            sel_d     = req_sel;
            req_d     = '{addr: addr, wr_en: wr_en, rd_en: rd_en, wr_data: wr_data};
            ext_req_d = N_EXT'(1) << req_sel;
            tmr_load  = 1'b1;
            state_d   = ST_WAIT;
          end else begin
            rd_data_d = ERR_RD;
            ack_d     = 1'b1;
            err_dec_d = 1'b1;
            state_d   = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        err_ovr_d  = req_vld;
        err_spur_d = |(ext_ack_vld & ~sel_mask);
        // An acknowledge arriving in the expiry cycle still completes cleanly.
        if (ext_ack_vld[sel_q]) begin
          rd_data_d = req_q.rd_en ? ext_rd_data[32'(sel_q)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] : '0;
          ack_d     = 1'b1;
          state_d   = ST_RESP;
        end else if (tmr_expired) begin
          rd_data_d = ERR_RD;
          ack_d     = 1'b1;
          err_to_d  = 1'b1;
          state_d   = ST_RESP;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_RESP: begin
        err_ovr_d  = req_vld;
        err_spur_d = |ext_ack_vld;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge native_clk) begin
    if (native_rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      req_q      <= '0;
      rd_data_q  <= '0;
      ext_req_q  <= '0;
      ack_q      <= 1'b0;
      err_to_q   <= 1'b0;
      err_dec_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
      err_spur_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      req_q      <= req_d;
      rd_data_q  <= rd_data_d;
      ext_req_q  <= ext_req_d;
      ack_q      <= ack_d;
      err_to_q   <= err_to_d;
      err_dec_q  <= err_dec_d;
      err_ovr_q  <= err_ovr_d;
      err_spur_q <= err_spur_d;
    end
  end

  assign ack_vld      = ack_q;
  assign rd_data      = rd_data_q;
  assign ext_req_vld  = ext_req_q;
  assign ext_addr     = req_q.addr;
  assign ext_wr_en    = req_q.wr_en;
  assign ext_rd_en    = req_q.rd_en;
  assign ext_wr_data  = req_q.wr_data;
  assign err_timeout  = err_to_q;
  assign err_decode   = err_dec_q;
  assign err_overrun  = err_ovr_q;
  assign err_spurious = err_spur_q;

endmodule

// File: tb/tb_reg_native_if_ext_fwd.sv
// Transaction bench: each window carries one request plus optional overrun/stray-ack injections,
// with the expected per-cycle waveform derived from the forwarder's timing rules.
module tb_reg_native_if_ext_fwd;

  localparam int          W      = 32;
  localparam int          AW     = 64;
  localparam int          N      = 5;
  localparam int          LSB    = 16;
  localparam int          SW     = 3;
  localparam int          TO     = 8;
  localparam int          WIN    = 18;
  localparam logic [31:0] ERR    = 32'hDEAD_BEEF;
  localparam int          P_ACK  = 9;
  localparam int          P_TO   = 8;
  localparam int          P_DEC  = 7;
  localparam int          P_OVR  = 6;
  localparam int          P_SPUR = 5;

  logic          native_clk = 1'b0;
  logic          native_rst;
  logic          req_vld, wr_en, rd_en, ack_vld, ext_wr_en, ext_rd_en;
  logic [AW-1:0] addr, ext_addr;
  logic [W-1:0]  wr_data, rd_data, ext_wr_data;
  logic [N-1:0]  ext_req_vld, ext_ack_vld;
  logic [N*W-1:0] ext_rd_data;
  logic          err_timeout, err_decode, err_overrun, err_spurious;

  always #5 native_clk = ~native_clk;

  reg_native_if_ext_fwd #(
    .BUS_DATA_WIDTH(W), .BUS_ADDR_WIDTH(AW), .N_EXT(N), .SEL_LSB(LSB),
    .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)
  ) dut (
    .native_clk(native_clk), .native_rst(native_rst), .req_vld(req_vld), .addr(addr),
    .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data), .ack_vld(ack_vld), .rd_data(rd_data),
    .ext_req_vld(ext_req_vld), .ext_addr(ext_addr), .ext_wr_en(ext_wr_en),
    .ext_rd_en(ext_rd_en), .ext_wr_data(ext_wr_data), .ext_ack_vld(ext_ack_vld),
    .ext_rd_data(ext_rd_data), .err_timeout(err_timeout), .err_decode(err_decode),
    .err_overrun(err_overrun), .err_spurious(err_spurious)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Stimulus per window cycle.
  logic          s_rst [WIN];
  logic          s_req [WIN];
  logic [AW-1:0] s_addr[WIN];
  logic          s_wr  [WIN];
  logic          s_rd  [WIN];
  logic [W-1:0]  s_wdat[WIN];
  logic [N-1:0]  s_ack [WIN];
  logic [N*W-1:0] s_rdat[WIN];
  // Expected outputs per window cycle.
  logic [9:0]    e_pulse[WIN];
  logic [W-1:0]  e_rdata[WIN];
  logic [AW-1:0] e_addr [WIN];
  logic          e_wr   [WIN];
  logic          e_rd   [WIN];
  logic [W-1:0]  e_wdat [WIN];
  // Values the forwarder should be holding between transactions.
  logic [AW-1:0] m_addr;
  logic          m_wr, m_rd;
  logic [W-1:0]  m_wdat, m_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h, want %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_window();
    for (int c = 0; c < WIN; c++) begin
      s_rst[c]   = 1'b0;
      s_req[c]   = 1'b0;
      s_addr[c]  = {$urandom, $urandom};
      s_wr[c]    = 1'($urandom);
      s_rd[c]    = 1'($urandom);
      s_wdat[c]  = $urandom;
      s_ack[c]   = '0;
      s_rdat[c]  = {$urandom, $urandom, $urandom, $urandom, $urandom};
      e_pulse[c] = '0;
      e_rdata[c] = m_rdata;
      e_addr[c]  = m_addr;
      e_wr[c]    = m_wr;
      e_rd[c]    = m_rd;
      e_wdat[c]  = m_wdat;
    end
  endtask

  task automatic run_window();
    for (int c = 0; c < WIN; c++) begin
      @(posedge native_clk);
      #1;
      native_rst  = s_rst[c];
      req_vld     = s_req[c];
      addr        = s_addr[c];
      wr_en       = s_wr[c];
      rd_en       = s_rd[c];
      wr_data     = s_wdat[c];
      ext_ack_vld = s_ack[c];
      ext_rd_data = s_rdat[c];
      @(negedge native_clk);
      cyc++;
      chk("pulses", {ack_vld, err_timeout, err_decode, err_overrun, err_spurious, ext_req_vld},
          e_pulse[c]);
      chk("rd_data", rd_data, e_rdata[c]);
      chk("ext_addr", ext_addr, e_addr[c]);
      chk("ext_ctl", {ext_wr_en, ext_rd_en, ext_wr_data}, {e_wr[c], e_rd[c], e_wdat[c]});
    end
  endtask

  task automatic do_txn(input int sel, input bit rd, input int lat, input bit ovr, input bit wrong,
                        input logic [AW-1:0] a_in, input logic [W-1:0] ipdat);
    logic [AW-1:0] a;
    logic [W-1:0]  res;
    int            ack_c, t, ch;
    clear_window();
    a             = a_in;
    a[LSB +: SW]  = SW'(sel);
    s_req[0]      = 1'b1;
    s_addr[0]     = a;
    s_wr[0]       = ~rd;
    s_rd[0]       = rd;
    if (sel >= N) begin
      ack_c = 1;
      res   = ERR;
      e_pulse[1][P_DEC] = 1'b1;
    end else begin
      e_pulse[1][sel]           = 1'b1;
      s_ack[1+lat][sel]         = 1'b1;
      s_rdat[1+lat][sel*W +: W] = ipdat;
      // Wait count in the ack cycle is lat+1; reaching TO in that same cycle still completes.
      if (lat + 1 <= TO) begin
        ack_c = lat + 2;
        res   = rd ? ipdat : '0;
      end else begin
        ack_c = TO + 1;
        res   = ERR;
        e_pulse[ack_c][P_TO]    = 1'b1;
        e_pulse[lat+2][P_SPUR]  = 1'b1;
      end
      for (int c = 1; c < WIN; c++) begin
        e_addr[c] = a;
        e_wr[c]   = ~rd;
        e_rd[c]   = rd;
        e_wdat[c] = s_wdat[0];
      end
      m_addr = a;
      m_wr   = ~rd;
      m_rd   = rd;
      m_wdat = s_wdat[0];
    end
    e_pulse[ack_c][P_ACK] = 1'b1;
    for (int c = ack_c; c < WIN; c++) e_rdata[c] = res;
    m_rdata = res;
    if (ovr) begin
      t = $urandom_range(ack_c, 1);
      s_req[t] = 1'b1;
      e_pulse[t+1][P_OVR] = 1'b1;
    end
    if (wrong) begin
      if (sel >= N) begin
        t  = 1;
        ch = $urandom_range(N - 1, 0);
      end else begin
        t  = $urandom_range(ack_c - 1, 1);
        ch = (sel + 1 + $urandom_range(N - 2, 0)) % N;
      end
      s_ack[t][ch] = 1'b1;
      e_pulse[t+1][P_SPUR] = 1'b1;
    end
    run_window();
  endtask

  task automatic rst_window();
    logic [AW-1:0] a;
    clear_window();
    a            = {$urandom, $urandom};
    a[LSB +: SW] = 3'd1;
    s_req[0]     = 1'b1;
    s_addr[0]    = a;
    s_wr[0]      = 1'b0;
    s_rd[0]      = 1'b1;
    e_pulse[1][1] = 1'b1;
    for (int c = 1; c < 3; c++) begin
      e_addr[c] = a;
      e_wr[c]   = 1'b0;
      e_rd[c]   = 1'b1;
      e_wdat[c] = s_wdat[0];
    end
    s_rst[2] = 1'b1;
    for (int c = 3; c < WIN; c++) begin
      e_addr[c]  = '0;
      e_wr[c]    = 1'b0;
      e_rd[c]    = 1'b0;
      e_wdat[c]  = '0;
      e_rdata[c] = '0;
    end
    // Ack for the aborted transaction arrives to an idle block: stray, no completion.
    s_ack[3][1]          = 1'b1;
    e_pulse[4][P_SPUR]   = 1'b1;
    m_addr  = '0;
    m_wr    = 1'b0;
    m_rd    = 1'b0;
    m_wdat  = '0;
    m_rdata = '0;
    run_window();
  endtask

  initial begin
    native_rst  = 1'b1;
    req_vld     = 1'b0;
    addr        = '0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    wr_data     = '0;
    ext_ack_vld = '0;
    ext_rd_data = '0;
    m_addr      = '0;
    m_wr        = 1'b0;
    m_rd        = 1'b0;
    m_wdat      = '0;
    m_rdata     = '0;
    repeat (3) @(posedge native_clk);
    @(negedge native_clk);
    chk("rst_pulses", {ack_vld, err_timeout, err_decode, err_overrun, err_spurious, ext_req_vld}, '0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_ext_addr", ext_addr, '0);
    chk("rst_ext_ctl", {ext_wr_en, ext_rd_en, ext_wr_data}, '0);

    do_txn(2, 1'b1, 3,  1'b0, 1'b0, 64'h2_0010, 32'h1234_5678);
    do_txn(0, 1'b0, 0,  1'b0, 1'b0, {$urandom, $urandom}, $urandom);
    do_txn(5, 1'b1, 0,  1'b0, 1'b0, {$urandom, $urandom}, $urandom);
    do_txn(3, 1'b1, 11, 1'b0, 1'b0, {$urandom, $urandom}, $urandom);
    do_txn(1, 1'b1, 4,  1'b1, 1'b1, {$urandom, $urandom}, $urandom);
    do_txn(4, 1'b1, 7,  1'b0, 1'b0, {$urandom, $urandom}, $urandom);
    rst_window();
    do_txn(1, 1'b1, 2,  1'b0, 1'b0, {$urandom, $urandom}, $urandom);
    for (int i = 0; i < 40; i++) begin
      do_txn($urandom_range(7, 0), 1'($urandom), $urandom_range(13, 0), 1'($urandom),
             1'($urandom), {$urandom, $urandom}, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
